// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: game-state encodings, colour
// constants used by the VGA colour path, grid limits and small helpers.
package snake_pkg;

   // Game state encoding, also driven straight onto MSM_STATE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_WIN  = 2'b10,
      ST_LOST = 2'b11
   } game_state_t;

   // 12-bit RGB colours shared with the VGA colour logic.
   localparam logic [11:0] COL_BACKGROUND = 12'h000;
   localparam logic [11:0] COL_SNAKE      = 12'h0F0;
   localparam logic [11:0] COL_TARGET     = 12'hF00;
   localparam logic [11:0] COL_WALL       = 12'h00F;
   localparam logic [11:0] COL_WIN        = 12'hFF0;
   localparam logic [11:0] COL_LOST       = 12'hF0F;

   // Playfield limits in cells.
   localparam logic [7:0] MAX_X = 8'd159;
   localparam logic [7:0] MAX_Y = 8'd119;

   // Increment that sticks at the top of the 8-bit range.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = 8'hFF;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Programmable-period pulse generator. Counts 0..PERIOD-1 while enabled and
// emits a registered one-cycle TRIG on the wrap. The period is sampled on
// CLEAR and on every wrap, so a changed PERIOD only applies from the next
// wrap onward. A period below 2 would make TRIG continuous.
module snake_tick_gen #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CLEAR,
   input  logic             ENABLE,
   input  logic [WIDTH-1:0] PERIOD,
   output logic             TRIG
);

   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] period_r;
   logic             trig_r;
   logic             last_s;

   assign last_s = ((cnt_r + WIDTH'(1)) >= period_r);
   assign TRIG   = trig_r;

   // Counter, latched period and registered wrap pulse.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_r    <= '0;
         period_r <= '0;
         trig_r   <= 1'b0;
      end else if (CLEAR) begin
         cnt_r    <= '0;
         period_r <= PERIOD;
         trig_r   <= 1'b0;
      end else if (ENABLE) begin
         if (last_s) begin
            cnt_r    <= '0;
            period_r <= PERIOD;
            trig_r   <= 1'b1;
         end else begin
            cnt_r    <= cnt_r + WIDTH'(1);
            trig_r   <= 1'b0;
         end
      end else begin
         trig_r <= 1'b0;
      end
   end

endmodule

// File: rtl/snake_game_sequencer.sv
// Master sequencer for the snake game: game FSM, move tick with
// score-dependent speed, target counting, countdown timer, win/loss.
// Optional feature macro: SNAKE_SPEEDUP_EN (move period shrinks with SCORE);
// without it the move period is fixed at TICK_BASE.
module snake_game_sequencer
   import snake_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned TICK_BASE  = 4000000,
   parameter int unsigned TICK_STEP  = 200000,
   parameter int unsigned TICK_MIN   = 1000000,
   parameter int unsigned WIN_SCORE  = 10,
   parameter int unsigned TIME_LIMIT = 60
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BTN_START,
   input  logic       TARGET_REACHED,
   input  logic       HIT_WALL,
   input  logic       TIMED_SW,
   output logic [1:0] MSM_STATE,
   output logic       SNAKE_RESET,
   output logic       MOVE_TICK,
   output logic       TARGET_NEW,
   output logic [7:0] SCORE,
   output logic [7:0] TIME_LEFT,
   output logic       TIMED_MODE
);

`ifdef SNAKE_SPEEDUP_EN
   localparam bit SPEEDUP_ON = 1'b1;
`else
   localparam bit SPEEDUP_ON = 1'b0;
`endif

   // With speed-up off the step is zero and the floor equals the base, so
   // the period collapses to the constant TICK_BASE.
   localparam int unsigned STEP_EFF = SPEEDUP_ON ? TICK_STEP : 32'd0;
   localparam int unsigned MIN_EFF  = SPEEDUP_ON ? TICK_MIN  : TICK_BASE;

   // max(MIN, BASE - score*STEP) without wrapping below zero.
   function automatic logic [31:0] move_period(input logic [7:0] score);
      logic [39:0] dec_v;
      logic [39:0] per_v;
      dec_v = 40'(score) * 40'(STEP_EFF);
      if (dec_v >= 40'(TICK_BASE)) begin
         per_v = 40'd0;
      end else begin
         per_v = 40'(TICK_BASE) - dec_v;
      end
      if (per_v < 40'(MIN_EFF)) begin
         per_v = 40'(MIN_EFF);
      end
      if (per_v == 40'd0) begin
         per_v = 40'd1;
      end
      return per_v[31:0];
   endfunction

   game_state_t state_r;
   game_state_t state_next_s;

   logic        snake_reset_r;
   logic        snake_reset_s;
   logic        target_new_r;
   logic        target_new_s;
   logic [7:0]  score_r;
   logic [7:0]  score_s;
   logic [7:0]  time_left_r;
   logic [7:0]  time_left_s;
   logic        timed_mode_r;
   logic        timed_mode_s;
   logic        tr_d_r;
   logic        tr_rise_r;
   logic        play_run_s;
   logic        count_s;
   logic        dec_s;
   logic        loss_s;
   logic        win_s;
   logic        sec_tick_s;
   logic        move_tick_s;
   logic [31:0] period_s;

   assign loss_s = HIT_WALL || (timed_mode_r && (time_left_r == 8'd0));
   assign win_s  = (score_r == 8'(WIN_SCORE));

   // A new game always starts at the score-0 period, not the frozen score.
   assign period_s = move_period(snake_reset_s ? 8'd0 : score_r);

   // Game state register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; in PLAY loss outranks win.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (BTN_START) state_next_s = ST_PLAY;
            else           state_next_s = ST_IDLE;
         end
         ST_PLAY: begin
            if (loss_s)     state_next_s = ST_LOST;
            else if (win_s) state_next_s = ST_WIN;
            else            state_next_s = ST_PLAY;
         end
         ST_WIN: begin
            if (BTN_START) state_next_s = ST_IDLE;
            else           state_next_s = ST_WIN;
         end
         ST_LOST: begin
            if (BTN_START) state_next_s = ST_IDLE;
            else           state_next_s = ST_LOST;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and game counters.
   always_comb begin
      play_run_s    = (state_r == ST_PLAY) && (state_next_s == ST_PLAY);
      snake_reset_s = (state_r == ST_IDLE) && BTN_START;
      // The datapath is still being reset in the first PLAY cycle, so an
      // overlap seen there is stale; skipping it also keeps TARGET_NEW
      // from following the start pulse back-to-back.
      count_s       = play_run_s && tr_rise_r && !snake_reset_r;
      dec_s         = play_run_s && sec_tick_s && timed_mode_r &&
                      (time_left_r != 8'd0);
      target_new_s  = snake_reset_s || count_s;
      score_s       = score_r;
      time_left_s   = time_left_r;
      timed_mode_s  = timed_mode_r;
      if (snake_reset_s) begin
         score_s      = 8'd0;
         timed_mode_s = TIMED_SW;
         time_left_s  = TIMED_SW ? 8'(TIME_LIMIT) : 8'd0;
      end else begin
         if (count_s) score_s = sat_inc8(score_r);
         else         score_s = score_r;
         if (dec_s)   time_left_s = time_left_r - 8'd1;
         else         time_left_s = time_left_r;
      end
   end

   // Registered outputs and game counters.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         snake_reset_r <= 1'b0;
         target_new_r  <= 1'b0;
         score_r       <= 8'd0;
         time_left_r   <= 8'd0;
         timed_mode_r  <= 1'b0;
      end else begin
         snake_reset_r <= snake_reset_s;
         target_new_r  <= target_new_s;
         score_r       <= score_s;
         time_left_r   <= time_left_s;
         timed_mode_r  <= timed_mode_s;
      end
   end

   // Registered rising-edge detect on the target-overlap level.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tr_d_r    <= 1'b0;
         tr_rise_r <= 1'b0;
      end else begin
         tr_d_r    <= TARGET_REACHED;
         tr_rise_r <= TARGET_REACHED && !tr_d_r;
      end
   end

   snake_tick_gen #(.WIDTH(32)) u_move_tick (
      .CLK    (CLK),
      .RESET  (RESET),
      .CLEAR  (snake_reset_s),
      .ENABLE (play_run_s),
      .PERIOD (period_s),
      .TRIG   (move_tick_s)
   );

   snake_tick_gen #(.WIDTH(32)) u_sec_tick (
      .CLK    (CLK),
      .RESET  (RESET),
      .CLEAR  (snake_reset_s),
      .ENABLE (play_run_s),
      .PERIOD (CLK_HZ),
      .TRIG   (sec_tick_s)
   );

   assign MSM_STATE   = state_r;
   assign SNAKE_RESET = snake_reset_r;
   assign MOVE_TICK   = move_tick_s;
   assign TARGET_NEW  = target_new_r;
   assign SCORE       = score_r;
   assign TIME_LEFT   = time_left_r;
   assign TIMED_MODE  = timed_mode_r;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Self-checking bench for snake_game_sequencer with small timing parameters.
module tb_snake_game_sequencer;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       BTN_START = 1'b0;
   logic       TARGET_REACHED = 1'b0;
   logic       HIT_WALL = 1'b0;
   logic       TIMED_SW = 1'b0;
   logic [1:0] MSM_STATE;
   logic       SNAKE_RESET;
   logic       MOVE_TICK;
   logic       TARGET_NEW;
   logic [7:0] SCORE;
   logic [7:0] TIME_LEFT;
   logic       TIMED_MODE;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int m_score  = 0;

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   exp_t exp_q[$];
   int   tick_q[$];

`ifdef SNAKE_SPEEDUP_EN
   localparam int P_SCORE1 = 8;
   localparam int P_SCORE2 = 6;
`else
   localparam int P_SCORE1 = 10;
   localparam int P_SCORE2 = 10;
`endif

   snake_game_sequencer #(
      .CLK_HZ     (20),
      .TICK_BASE  (10),
      .TICK_STEP  (2),
      .TICK_MIN   (4),
      .WIN_SCORE  (3),
      .TIME_LIMIT (2)
   ) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .BTN_START      (BTN_START),
      .TARGET_REACHED (TARGET_REACHED),
      .HIT_WALL       (HIT_WALL),
      .TIMED_SW       (TIMED_SW),
      .MSM_STATE      (MSM_STATE),
      .SNAKE_RESET    (SNAKE_RESET),
      .MOVE_TICK      (MOVE_TICK),
      .TARGET_NEW     (TARGET_NEW),
      .SCORE          (SCORE),
      .TIME_LEFT      (TIME_LEFT),
      .TIMED_MODE     (TIMED_MODE)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      step();
      step();
      n_checks++;
      if (MSM_STATE !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d want 0", MSM_STATE); end
      n_checks++;
      if ({SNAKE_RESET, MOVE_TICK, TARGET_NEW} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {SNAKE_RESET, MOVE_TICK, TARGET_NEW}); end
      n_checks++;
      if ({SCORE, TIME_LEFT, TIMED_MODE} !== 17'd0) begin n_fail++; $display("FAIL reset_counts: score %0d time %0d timed %0d want 0", SCORE, TIME_LEFT, TIMED_MODE); end
      RESET = 1'b0;
      step();
      n_checks++;
      if (MSM_STATE !== 2'b00) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", MSM_STATE); end
   endtask

   // Starts a game; returns with the bench in the cycle after the SNAKE_RESET cycle.
   task automatic start_game(input logic timed, output int c0);
      TIMED_SW  = timed;
      BTN_START = 1'b1;
      step();
      BTN_START = 1'b0;
      c0 = cyc;
      m_score = 0;
      n_checks++;
      if (SNAKE_RESET !== 1'b1 || TARGET_NEW !== 1'b1) begin n_fail++; $display("FAIL start_pulses: snake_reset %b target_new %b want 1 1", SNAKE_RESET, TARGET_NEW); end
      n_checks++;
      if (MSM_STATE !== 2'b01) begin n_fail++; $display("FAIL start_state: got %0d want 1", MSM_STATE); end
      n_checks++;
      if (SCORE !== 8'd0 || TIMED_MODE !== timed || TIME_LEFT !== (timed ? 8'd2 : 8'd0)) begin
         n_fail++; $display("FAIL start_counts: score %0d timed %b time %0d", SCORE, TIMED_MODE, TIME_LEFT);
      end
      step();
      n_checks++;
      if (SNAKE_RESET !== 1'b0 || TARGET_NEW !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width: snake_reset %b target_new %b want 0 0", SNAKE_RESET, TARGET_NEW); end
   endtask

   task automatic test_move_tick(input int c0);
      tick_q.delete();
      tick_q.push_back(c0 + 10);
      tick_q.push_back(c0 + 20);
      tick_q.push_back(c0 + 30);
      while (cyc < c0 + 35) begin
         step();
         if (MOVE_TICK) begin
            n_checks++;
            if (tick_q.size() == 0) begin
               n_fail++; $display("FAIL move_tick_extra: tick at cycle %0d, none expected", cyc - c0);
            end else begin
               int e;
               e = tick_q.pop_front();
               if (cyc !== e) begin n_fail++; $display("FAIL move_tick_time: got cycle %0d want %0d", cyc - c0, e - c0); end
            end
         end
      end
      n_checks++;
      if (tick_q.size() != 0) begin n_fail++; $display("FAIL move_tick_missing: %0d ticks outstanding want 0", tick_q.size()); end
   endtask

   // Raises TARGET_REACHED for 'hold' cycles and checks the single counted response.
   task automatic do_target(input int hold);
      exp_t e;
      m_score = (m_score == 255) ? 255 : m_score + 1;
      e.cyc = cyc + 2;
      e.val = m_score;
      exp_q.push_back(e);
      TARGET_REACHED = 1'b1;
      for (int i = 0; i < hold + 5; i++) begin
         if (i == hold) TARGET_REACHED = 1'b0;
         step();
         if (TARGET_NEW) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL target_extra: TARGET_NEW with score %0d, none expected", SCORE);
            end else begin
               e = exp_q.pop_front();
               if (SCORE !== 8'(e.val) || cyc != e.cyc) begin
                  n_fail++; $display("FAIL target_count: score %0d at +%0d want %0d at +%0d", SCORE, cyc - e.cyc + 2, e.val, 2);
               end
            end
         end
      end
      TARGET_REACHED = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL target_missing: %0d outstanding want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic measure_period(output int per);
      int t0;
      t0  = -1;
      per = -1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (MOVE_TICK) begin
            if (t0 < 0) begin
               t0 = cyc;
            end else begin
               per = cyc - t0;
               break;
            end
         end
      end
   endtask

   task automatic test_target_and_speed();
      int per;
      do_target(5);
      measure_period(per);
      n_checks++;
      if (per !== P_SCORE1) begin n_fail++; $display("FAIL period_score1: got %0d want %0d", per, P_SCORE1); end
      do_target(1);
      measure_period(per);
      n_checks++;
      if (per !== P_SCORE2) begin n_fail++; $display("FAIL period_score2: got %0d want %0d", per, P_SCORE2); end
   endtask

   task automatic test_win();
      int ticks;
      TARGET_REACHED = 1'b1;
      step();
      TARGET_REACHED = 1'b0;
      step();
      n_checks++;
      if (SCORE !== 8'd3 || TARGET_NEW !== 1'b1 || MSM_STATE !== 2'b01) begin
         n_fail++; $display("FAIL win_score: score %0d target_new %b state %0d want 3 1 1", SCORE, TARGET_NEW, MSM_STATE);
      end
      step();
      n_checks++;
      if (MSM_STATE !== 2'b10) begin n_fail++; $display("FAIL win_state: got %0d want 2", MSM_STATE); end
      ticks = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (MOVE_TICK) ticks++;
      end
      n_checks++;
      if (ticks != 0 || SCORE !== 8'd3 || MSM_STATE !== 2'b10) begin
         n_fail++; $display("FAIL win_frozen: ticks %0d score %0d state %0d want 0 3 2", ticks, SCORE, MSM_STATE);
      end
   endtask

   task automatic return_idle(input logic [7:0] frozen);
      BTN_START = 1'b1;
      step();
      BTN_START = 1'b0;
      n_checks++;
      if (MSM_STATE !== 2'b00 || SNAKE_RESET !== 1'b0 || TARGET_NEW !== 1'b0) begin
         n_fail++; $display("FAIL to_idle: state %0d snake_reset %b target_new %b want 0 0 0", MSM_STATE, SNAKE_RESET, TARGET_NEW);
      end
      n_checks++;
      if (SCORE !== frozen) begin n_fail++; $display("FAIL idle_score: got %0d want %0d", SCORE, frozen); end
   endtask

   task automatic test_timed();
      int   c0;
      logic [7:0] prev;
      exp_t e;
      start_game(1'b1, c0);
      e.cyc = c0 + 21; e.val = 1; exp_q.push_back(e);
      e.cyc = c0 + 41; e.val = 0; exp_q.push_back(e);
      prev = TIME_LEFT;
      while (cyc < c0 + 41) begin
         step();
         if (TIME_LEFT !== prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL timer_extra: TIME_LEFT %0d at cycle %0d", TIME_LEFT, cyc - c0);
            end else begin
               e = exp_q.pop_front();
               if (TIME_LEFT !== 8'(e.val) || cyc != e.cyc) begin
                  n_fail++; $display("FAIL timer_step: %0d at cycle %0d want %0d at %0d", TIME_LEFT, cyc - c0, e.val, e.cyc - c0);
               end
            end
            prev = TIME_LEFT;
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL timer_missing: %0d outstanding want 0", exp_q.size()); exp_q.delete(); end
      n_checks++;
      if (MSM_STATE !== 2'b01) begin n_fail++; $display("FAIL timer_still_play: got %0d want 1", MSM_STATE); end
      step();
      n_checks++;
      if (MSM_STATE !== 2'b11 || TIME_LEFT !== 8'd0) begin n_fail++; $display("FAIL timer_lost: state %0d time %0d want 3 0", MSM_STATE, TIME_LEFT); end
   endtask

   task automatic test_collision_priority();
      int c0;
      int tn;
      start_game(1'b0, c0);
      do_target(1);
      do_target(1);
      HIT_WALL = 1'b1;
      TARGET_REACHED = 1'b1;
      step();
      HIT_WALL = 1'b0;
      n_checks++;
      if (MSM_STATE !== 2'b11) begin n_fail++; $display("FAIL wall_state: got %0d want 3", MSM_STATE); end
      tn = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) TARGET_REACHED = 1'b0;
         step();
         if (TARGET_NEW) tn++;
      end
      n_checks++;
      if (SCORE !== 8'd2 || tn != 0) begin n_fail++; $display("FAIL wall_priority: score %0d target_new %0d want 2 0", SCORE, tn); end
   endtask

   task automatic test_reset_midgame();
      int c0;
      start_game(1'b1, c0);
      do_target(1);
      do_target(1);
      n_checks++;
      if (SCORE !== 8'd2 || MSM_STATE !== 2'b01) begin n_fail++; $display("FAIL pre_reset: score %0d state %0d want 2 1", SCORE, MSM_STATE); end
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      n_checks++;
      if (MSM_STATE !== 2'b00 || SCORE !== 8'd0 || TIME_LEFT !== 8'd0 || TIMED_MODE !== 1'b0) begin
         n_fail++; $display("FAIL midgame_reset: state %0d score %0d time %0d timed %b", MSM_STATE, SCORE, TIME_LEFT, TIMED_MODE);
      end
      n_checks++;
      if ({SNAKE_RESET, MOVE_TICK, TARGET_NEW} !== 3'b000) begin n_fail++; $display("FAIL midgame_reset_pulses: got %b want 000", {SNAKE_RESET, MOVE_TICK, TARGET_NEW}); end
      step();
      n_checks++;
      if (MSM_STATE !== 2'b00 || {SNAKE_RESET, MOVE_TICK, TARGET_NEW} !== 3'b000) begin
         n_fail++; $display("FAIL post_reset_idle: state %0d pulses %b", MSM_STATE, {SNAKE_RESET, MOVE_TICK, TARGET_NEW});
      end
   endtask

   initial begin
      int c0;
      test_reset();
      start_game(1'b0, c0);
      test_move_tick(c0);
      test_target_and_speed();
      test_win();
      return_idle(8'd3);
      test_timed();
      return_idle(8'd0);
      test_collision_priority();
      return_idle(8'd2);
      test_reset_midgame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
